pifo_calendar_v0_3: RTL and testbench
=====================================

PIFO_CALENDAR_V0_3 -- requirements
Module: pifo_calendar_v0_3

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  PIFO_DEPTH  16  number of entries, power of two, >=4
  PIFO_INDEX_WIDTH  4  log2(PIFO_DEPTH)
  ELEMENT_WIDTH  32  entry width
  RANK_START_POS  12  rank LSB
  RANK_WIDTH  19  rank field width
  VALID_POS  31  entry valid bit
  BUFFER_ADDR_WIDTH  12  buffer address, bits [BUFFER_ADDR_WIDTH-1:0]
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  sole clock
  rstn  in  1  reset, asynchronous, active-low
  s_axis_insert_en  in  1  insert request
  s_axis_pifo_info  in  ELEMENT_WIDTH  element to insert
  s_axis_pop_en  in  1  pop request
  m_axis_head_data  out  ELEMENT_WIDTH  entry 0
  m_axis_buffer_addr  out  BUFFER_ADDR_WIDTH  entry 0 buffer address
  m_axis_buffer_addr_valid  out  1  entry 0 VALID_POS bit
  m_axis_calendar_full / m_axis_calendar_empty  out  1 each  count==PIFO_DEPTH / count==0
  m_axis_count  out  PIFO_INDEX_WIDTH+1  occupied entries
  m_axis_drop  out  1  one-cycle pulse, insert rejected
  cpu_rd_valid / cpu_rd_addr  in  1 / PIFO_INDEX_WIDTH  read request / index
  cpu_rd_result_valid / cpu_rd_result  out  1 / ELEMENT_WIDTH  read response
  cpu_wr_valid / cpu_wr_addr / cpu_wr_data  in  1 / PIFO_INDEX_WIDTH / ELEMENT_WIDTH  write request
  cpu_wr_result_valid  out  1  write-complete pulse
  cpu_busy  out  1  CPU channel not IDLE

Function
REQ-003 Entries SHALL be held sorted by unsigned rank ascending, entry 0 = head; unoccupied entries SHALL be all-zero.
REQ-004 Insert position SHALL equal number of occupied entries with rank <= new rank (FIFO order among equal ranks); entries at and behind it shift one toward tail.
REQ-005 Pop SHALL remove entry 0 and shift all entries one toward head; tail entry becomes zero.
REQ-006 Insert and pop in same cycle SHALL both take effect, count unchanged, legal when full; new element ranked against remaining entries 1..count-1.
REQ-007 Insert when full without pop SHALL be discarded; m_axis_drop SHALL be 1 for the following cycle only.
REQ-008 Pop when empty SHALL be ignored; insert+pop when empty SHALL behave as a plain insert.
REQ-009 All head/status outputs SHALL be registered; an operation in cycle N is visible in cycle N+1.
REQ-010 CPU FSM SHALL have states IDLE, WR_PEND, RD_RESP; cpu_busy=1 outside IDLE; requests while busy SHALL be ignored.
REQ-011 IDLE: cpu_wr_valid SHALL capture addr/data, go WR_PEND; else cpu_rd_valid SHALL capture entry[cpu_rd_addr] into cpu_rd_result, go RD_RESP; write wins if both.
REQ-012 WR_PEND: in first cycle with no insert and no pop the entry SHALL be overwritten (no re-sort, count unchanged), cpu_wr_result_valid pulses next cycle, return to IDLE.
REQ-013 RD_RESP: cpu_rd_result_valid SHALL be 1 for one cycle, return to IDLE; cpu_rd_result holds value until next read.

Reset
REQ-014 rstn low SHALL asynchronously clear all entries, count, drop, FSM (IDLE) and CPU outputs; empty=1, full=0.
REQ-015 Reset mid-operation SHALL abandon any pending CPU write with no result pulse.

Configuration
REQ-016 Macro PIFO_CALENDAR_CPU_ACCESS_EN SHALL gate the CPU channel; defined: REQ-010..013 apply; undefined: CPU ports remain, inputs ignored, cpu_* outputs and cpu_busy tied 0, no FSM logic.

Verification
REQ-017 Insert ranks 5,2,9 on consecutive cycles -> entries 0..2 ranks 2,5,9, count 3.
REQ-018 Insert two rank-7 elements addr 0x11 then 0x22, pop -> head addr 0x11 first, then 0x22.
REQ-019 Fill 16 entries, insert alone -> m_axis_drop 1 one cycle, count 16; then insert rank 0 + pop -> count 16, head rank 0.
REQ-020 CPU write idx 3 data 0x8000_1234 while insert each cycle for 4 cycles -> write applied 5th cycle, cpu_wr_result_valid following cycle.
REQ-021 CPU read idx 1 with entry rank 5 -> cpu_rd_result_valid next cycle, data matches; second read during busy ignored.
REQ-022 Assert rstn low during WR_PEND -> all entries zero, empty=1, no cpu_wr_result_valid.

Source files
------------

// File: rtl/pifo_calendar_v0_3.sv
// Sorted PIFO calendar: entries held in ascending unsigned rank order, entry 0 is the head.
// Latency: insert/pop/CPU write take effect at the clock edge, visible on outputs the next cycle.
// Backpressure: none; insert when full (no pop) is dropped with a one-cycle m_axis_drop pulse.
//
// Ports: s_axis_insert_en/s_axis_pifo_info insert an element, s_axis_pop_en removes the head;
// m_axis_* expose the head entry and occupancy status; cpu_* is an optional single-outstanding
// read/write side channel into the entry array, enabled by defining PIFO_CALENDAR_CPU_ACCESS_EN.
// With the macro undefined the CPU ports exist but are ignored and cpu_* outputs are tied to 0.
module pifo_calendar_v0_3 #(
    parameter int PIFO_DEPTH        = 16,
    parameter int PIFO_INDEX_WIDTH  = 4,
    parameter int ELEMENT_WIDTH     = 32,
    parameter int RANK_START_POS    = 12,
    parameter int RANK_WIDTH        = 19,
    parameter int VALID_POS         = 31,
    parameter int BUFFER_ADDR_WIDTH = 12
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         s_axis_insert_en,
    input  logic [ELEMENT_WIDTH-1:0]     s_axis_pifo_info,
    input  logic                         s_axis_pop_en,
    output logic [ELEMENT_WIDTH-1:0]     m_axis_head_data,
    output logic [BUFFER_ADDR_WIDTH-1:0] m_axis_buffer_addr,
    output logic                         m_axis_buffer_addr_valid,
    output logic                         m_axis_calendar_full,
    output logic                         m_axis_calendar_empty,
    output logic [PIFO_INDEX_WIDTH:0]    m_axis_count,
    output logic                         m_axis_drop,
    input  logic                         cpu_rd_valid,
    input  logic [PIFO_INDEX_WIDTH-1:0]  cpu_rd_addr,
    output logic                         cpu_rd_result_valid,
    output logic [ELEMENT_WIDTH-1:0]     cpu_rd_result,
    input  logic                         cpu_wr_valid,
    input  logic [PIFO_INDEX_WIDTH-1:0]  cpu_wr_addr,
    input  logic [ELEMENT_WIDTH-1:0]     cpu_wr_data,
    output logic                         cpu_wr_result_valid,
    output logic                         cpu_busy
);

    localparam int CW = PIFO_INDEX_WIDTH + 1;

    logic [ELEMENT_WIDTH-1:0] mem_q    [PIFO_DEPTH];
    logic [ELEMENT_WIDTH-1:0] base     [PIFO_DEPTH];
    logic [ELEMENT_WIDTH-1:0] mem_nxt  [PIFO_DEPTH];
    logic [CW-1:0]            count_q;
    logic [CW-1:0]            base_count;
    logic [CW-1:0]            count_nxt;
    logic [CW-1:0]            ins_pos;
    logic [RANK_WIDTH-1:0]    new_rank;
    logic                     pop_go;
    logic                     ins_go;
    logic                     drop_q;
    logic                     full_q;
    logic                     empty_q;

    // CPU write port into the array; tied off when the CPU channel is compiled out.
    logic                        cpu_wr_fire;
    logic [PIFO_INDEX_WIDTH-1:0] cpu_wr_addr_q;
    logic [ELEMENT_WIDTH-1:0]    cpu_wr_data_q;

    assign new_rank = s_axis_pifo_info[RANK_START_POS +: RANK_WIDTH];
    assign pop_go   = s_axis_pop_en && (count_q != '0);
    // A pop in the same cycle frees a slot, so a full calendar still accepts the insert.
    assign ins_go   = s_axis_insert_en && (pop_go || (count_q != CW'(PIFO_DEPTH)));

    always_comb begin
        // Stage 1: apply the pop (shift toward head) so the insert is ranked against survivors.
        for (int i = 0; i < PIFO_DEPTH - 1; i++) begin
            base[i] = pop_go ? mem_q[i+1] : mem_q[i];
        end
        base[PIFO_DEPTH-1] = pop_go ? '0 : mem_q[PIFO_DEPTH-1];
        base_count = count_q - {{PIFO_INDEX_WIDTH{1'b0}}, pop_go};

        // Entries are sorted, so the number of occupied entries with rank <= new rank is the
        // slot just behind the last equal rank, which keeps FIFO order among ties.
        ins_pos = '0;
        for (int i = 0; i < PIFO_DEPTH; i++) begin
            if ((CW'(i) < base_count) &&
                (base[i][RANK_START_POS +: RANK_WIDTH] <= new_rank)) begin
                ins_pos = ins_pos + CW'(1);
            end
        end

        // Stage 2: open a hole at ins_pos and drop the new element into it.
        for (int i = 0; i < PIFO_DEPTH; i++) begin
            mem_nxt[i] = base[i];
        end
        if (ins_go) begin
            mem_nxt[0] = (ins_pos == '0) ? s_axis_pifo_info : base[0];
            for (int i = 1; i < PIFO_DEPTH; i++) begin
                if (CW'(i) < ins_pos) begin
                    mem_nxt[i] = base[i];
                end else if (CW'(i) == ins_pos) begin
                    mem_nxt[i] = s_axis_pifo_info;
                end else begin
                    mem_nxt[i] = base[i-1];
                end
            end
        end
        count_nxt = base_count + {{PIFO_INDEX_WIDTH{1'b0}}, ins_go};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < PIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            count_q <= '0;
            drop_q  <= 1'b0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            // CPU writes only fire in cycles with no insert/pop, so mem_nxt equals mem_q then.
            if (cpu_wr_fire) begin
                mem_q[cpu_wr_addr_q] <= cpu_wr_data_q;
            end else begin
                for (int i = 0; i < PIFO_DEPTH; i++) begin
                    mem_q[i] <= mem_nxt[i];
                end
            end
            count_q <= count_nxt;
            drop_q  <= s_axis_insert_en && !s_axis_pop_en && (count_q == CW'(PIFO_DEPTH));
            full_q  <= (count_nxt == CW'(PIFO_DEPTH));
            empty_q <= (count_nxt == '0);
        end
    end

    assign m_axis_head_data         = mem_q[0];
    assign m_axis_buffer_addr       = mem_q[0][BUFFER_ADDR_WIDTH-1:0];
    assign m_axis_buffer_addr_valid = mem_q[0][VALID_POS];
    assign m_axis_calendar_full     = full_q;
    assign m_axis_calendar_empty    = empty_q;
    assign m_axis_count             = count_q;
    assign m_axis_drop              = drop_q;

`ifdef PIFO_CALENDAR_CPU_ACCESS_EN
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_PEND = 2'd1,
        RD_RESP = 2'd2
    } cpu_state_t;

    cpu_state_t state_q;
    cpu_state_t state_nxt;
    logic       rd_result_valid_q;
    logic       wr_result_valid_q;
    logic [ELEMENT_WIDTH-1:0] rd_result_q;
    logic       rd_accept;
    logic       wr_accept;

    assign wr_accept   = (state_q == IDLE) && cpu_wr_valid;
    assign rd_accept   = (state_q == IDLE) && !cpu_wr_valid && cpu_rd_valid;
    // The pending write waits for a quiet cycle so it never races a shift of the array.
    assign cpu_wr_fire = (state_q == WR_PEND) && !s_axis_insert_en && !s_axis_pop_en;

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE: begin
                if (cpu_wr_valid) begin
                    state_nxt = WR_PEND;
                end else if (cpu_rd_valid) begin
                    state_nxt = RD_RESP;
                end
            end
            WR_PEND: begin
                if (cpu_wr_fire) begin
                    state_nxt = IDLE;
                end
            end
            RD_RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cpu_wr_addr_q     <= '0;
            cpu_wr_data_q     <= '0;
            rd_result_q       <= '0;
            rd_result_valid_q <= 1'b0;
            wr_result_valid_q <= 1'b0;
        end else begin
            if (wr_accept) begin
                cpu_wr_addr_q <= cpu_wr_addr;
                cpu_wr_data_q <= cpu_wr_data;
            end
            if (rd_accept) begin
                rd_result_q <= mem_q[cpu_rd_addr];
            end
            rd_result_valid_q <= rd_accept;
            wr_result_valid_q <= cpu_wr_fire;
        end
    end

    assign cpu_rd_result_valid = rd_result_valid_q;
    assign cpu_rd_result       = rd_result_q;
    assign cpu_wr_result_valid = wr_result_valid_q;
    assign cpu_busy            = (state_q != IDLE);
`else
    logic unused_cpu_inputs;

    assign unused_cpu_inputs   = ^{cpu_rd_valid, cpu_rd_addr, cpu_wr_valid, cpu_wr_addr, cpu_wr_data};
    assign cpu_wr_fire         = 1'b0;
    assign cpu_wr_addr_q       = '0;
    assign cpu_wr_data_q       = '0;
    assign cpu_rd_result_valid = 1'b0;
    assign cpu_rd_result       = '0;
    assign cpu_wr_result_valid = 1'b0;
    assign cpu_busy            = 1'b0;
`endif

endmodule

// File: tb/tb_pifo_calendar_v0_3.sv
// Testbench for pifo_calendar_v0_3: directed vector table, hand-written corner sequences
// (drop when full, insert+pop when full, async reset) and a randomized run against a queue model.
// CPU channel sequences are exercised when PIFO_CALENDAR_CPU_ACCESS_EN is defined.
module tb_pifo_calendar_v0_3;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        ins = 1'b0;
    logic [31:0] info = '0;
    logic        pop = 1'b0;
    logic [31:0] head_data;
    logic [11:0] buf_addr;
    logic        buf_vld;
    logic        full;
    logic        empty;
    logic [4:0]  count;
    logic        drop;
    logic        cpu_rd_valid = 1'b0;
    logic [3:0]  cpu_rd_addr = '0;
    logic        cpu_rd_result_valid;
    logic [31:0] cpu_rd_result;
    logic        cpu_wr_valid = 1'b0;
    logic [3:0]  cpu_wr_addr = '0;
    logic [31:0] cpu_wr_data = '0;
    logic        cpu_wr_result_valid;
    logic        cpu_busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pifo_calendar_v0_3 dut (
        .clk                      (clk),
        .rstn                     (rstn),
        .s_axis_insert_en         (ins),
        .s_axis_pifo_info         (info),
        .s_axis_pop_en            (pop),
        .m_axis_head_data         (head_data),
        .m_axis_buffer_addr       (buf_addr),
        .m_axis_buffer_addr_valid (buf_vld),
        .m_axis_calendar_full     (full),
        .m_axis_calendar_empty    (empty),
        .m_axis_count             (count),
        .m_axis_drop              (drop),
        .cpu_rd_valid             (cpu_rd_valid),
        .cpu_rd_addr              (cpu_rd_addr),
        .cpu_rd_result_valid      (cpu_rd_result_valid),
        .cpu_rd_result            (cpu_rd_result),
        .cpu_wr_valid             (cpu_wr_valid),
        .cpu_wr_addr              (cpu_wr_addr),
        .cpu_wr_data              (cpu_wr_data),
        .cpu_wr_result_valid      (cpu_wr_result_valid),
        .cpu_busy                 (cpu_busy)
    );

    // Element layout: valid bit 31, rank bits 30:12, buffer address bits 11:0.
    function automatic logic [31:0] mk(input int rank, input int addr);
        return {1'b1, 19'(rank), 12'(addr)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: a sorted queue of elements.
    logic [31:0] mq[$];

    task automatic model_step(input logic m_ins, input logic m_pop, input logic [31:0] v,
                              output logic m_drop);
        int p;
        m_drop = 1'b0;
        if (m_ins && !m_pop && mq.size() == 16) begin
            m_drop = 1'b1;
        end else begin
            if (m_pop && mq.size() > 0) void'(mq.pop_front());
            if (m_ins) begin
                p = 0;
                foreach (mq[j]) if (mq[j][30:12] <= v[30:12]) p++;
                mq.insert(p, v);
            end
        end
    endtask

    task automatic chk_status(input string nm);
        logic [31:0] eh;
        eh = (mq.size() > 0) ? mq[0] : 32'h0;
        chk({nm, "_count"}, 64'(count), 64'(mq.size()));
        chk({nm, "_head"}, 64'(head_data), 64'(eh));
        chk({nm, "_addr"}, 64'(buf_addr), 64'(eh[11:0]));
        chk({nm, "_vbit"}, 64'(buf_vld), 64'(eh[31]));
        chk({nm, "_full"}, 64'(full), 64'(mq.size() == 16));
        chk({nm, "_empty"}, 64'(empty), 64'(mq.size() == 0));
    endtask

    typedef struct {
        logic v_ins;
        logic v_pop;
        int   rank;
        int   addr;
        int   exp_count;
        int   exp_rank;
        int   exp_addr;
    } vec_t;

    vec_t tbl[11];

    initial begin
        logic        exp_drop;
        logic [31:0] eh;
        int          rk[4];

        tbl[0]  = '{1'b1, 1'b0, 5, 1,     1, 5, 1};
        tbl[1]  = '{1'b1, 1'b0, 2, 2,     2, 2, 2};
        tbl[2]  = '{1'b1, 1'b0, 9, 3,     3, 2, 2};
        tbl[3]  = '{1'b0, 1'b1, 0, 0,     2, 5, 1};
        tbl[4]  = '{1'b0, 1'b1, 0, 0,     1, 9, 3};
        tbl[5]  = '{1'b0, 1'b1, 0, 0,     0, 0, 0};
        tbl[6]  = '{1'b0, 1'b1, 0, 0,     0, 0, 0};
        tbl[7]  = '{1'b1, 1'b1, 7, 'h11,  1, 7, 'h11};
        tbl[8]  = '{1'b1, 1'b0, 7, 'h22,  2, 7, 'h11};
        tbl[9]  = '{1'b0, 1'b1, 0, 0,     1, 7, 'h22};
        tbl[10] = '{1'b0, 1'b1, 0, 0,     0, 0, 0};

        // Reset state
        #12;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_head", 64'(head_data), 64'd0);
        chk("rst_drop", 64'(drop), 64'd0);
        chk("rst_busy", 64'(cpu_busy), 64'd0);
        rstn = 1'b1;
        tick();

        // Directed table: sort order, FIFO among ties, pop on empty, insert+pop on empty.
        for (int k = 0; k < 11; k++) begin
            ins  = tbl[k].v_ins;
            pop  = tbl[k].v_pop;
            info = tbl[k].v_ins ? mk(tbl[k].rank, tbl[k].addr) : 32'h0;
            tick();
            eh = (tbl[k].exp_count == 0) ? 32'h0 : mk(tbl[k].exp_rank, tbl[k].exp_addr);
            chk($sformatf("tbl%0d_count", k), 64'(count), 64'(tbl[k].exp_count));
            chk($sformatf("tbl%0d_head", k), 64'(head_data), 64'(eh));
            chk($sformatf("tbl%0d_drop", k), 64'(drop), 64'd0);
        end
        ins = 1'b0;
        pop = 1'b0;

        // Fill to full, then insert alone (dropped) and insert+pop (accepted).
        for (int k = 0; k < 16; k++) begin
            ins  = 1'b1;
            info = mk(100 + k, k);
            tick();
        end
        chk("fill_count", 64'(count), 64'd16);
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_head", 64'(head_data), 64'(mk(100, 0)));
        info = mk(1, 'h55);
        tick();
        ins = 1'b0;
        chk("drop_pulse", 64'(drop), 64'd1);
        chk("drop_count", 64'(count), 64'd16);
        chk("drop_head", 64'(head_data), 64'(mk(100, 0)));
        tick();
        chk("drop_clear", 64'(drop), 64'd0);
        ins  = 1'b1;
        pop  = 1'b1;
        info = mk(0, 'h66);
        tick();
        chk("fullswap_count", 64'(count), 64'd16);
        chk("fullswap_head", 64'(head_data), 64'(mk(0, 'h66)));
        chk("fullswap_drop", 64'(drop), 64'd0);
        ins = 1'b0;
        tick();
        chk("fullswap_pop_head", 64'(head_data), 64'(mk(101, 1)));
        chk("fullswap_pop_count", 64'(count), 64'd15);
        pop = 1'b0;

        // Asynchronous reset in the middle of a cycle.
        ins  = 1'b1;
        info = mk(3, 3);
        #2 rstn = 1'b0;
        #1;
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_head", 64'(head_data), 64'd0);
        chk("arst_empty", 64'(empty), 64'd1);
        chk("arst_full", 64'(full), 64'd0);
        ins = 1'b0;
        #1 rstn = 1'b1;
        mq.delete();

`ifdef PIFO_CALENDAR_CPU_ACCESS_EN
        // CPU write held off by four cycles of inserts.
        rk = '{1, 5, 6, 7};
        cpu_wr_valid = 1'b1;
        cpu_wr_addr  = 4'd3;
        cpu_wr_data  = 32'h8000_1234;
        ins  = 1'b1;
        info = mk(rk[0], 16);
        tick();
        cpu_wr_valid = 1'b0;
        chk("wr_busy0", 64'(cpu_busy), 64'd1);
        for (int k = 1; k < 4; k++) begin
            info = mk(rk[k], 16 + k);
            tick();
            chk($sformatf("wr_busy%0d", k), 64'(cpu_busy), 64'd1);
            chk($sformatf("wr_nores%0d", k), 64'(cpu_wr_result_valid), 64'd0);
        end
        ins = 1'b0;
        tick();
        chk("wr_result", 64'(cpu_wr_result_valid), 64'd1);
        chk("wr_idle", 64'(cpu_busy), 64'd0);
        chk("wr_count", 64'(count), 64'd4);
        tick();
        chk("wr_result_pulse", 64'(cpu_wr_result_valid), 64'd0);

        // CPU read of entry 1, with a second read attempted while busy.
        cpu_rd_valid = 1'b1;
        cpu_rd_addr  = 4'd1;
        tick();
        cpu_rd_addr = 4'd0;
        chk("rd_valid", 64'(cpu_rd_result_valid), 64'd1);
        chk("rd_data", 64'(cpu_rd_result), 64'(mk(5, 17)));
        chk("rd_busy", 64'(cpu_busy), 64'd1);
        tick();
        cpu_rd_valid = 1'b0;
        chk("rd2_ignored_valid", 64'(cpu_rd_result_valid), 64'd0);
        chk("rd2_ignored_hold", 64'(cpu_rd_result), 64'(mk(5, 17)));
        tick();
        chk("rd2_no_late_resp", 64'(cpu_rd_result_valid), 64'd0);
        cpu_rd_valid = 1'b1;
        cpu_rd_addr  = 4'd3;
        tick();
        cpu_rd_valid = 1'b0;
        chk("rd_written", 64'(cpu_rd_result), 64'h8000_1234);
        tick();

        // Reset while a write is pending.
        cpu_wr_valid = 1'b1;
        cpu_wr_addr  = 4'd0;
        cpu_wr_data  = 32'hDEAD_BEEF;
        ins  = 1'b1;
        info = mk(9, 9);
        tick();
        cpu_wr_valid = 1'b0;
        chk("wrp_busy", 64'(cpu_busy), 64'd1);
        #2 rstn = 1'b0;
        #1;
        chk("wrp_rst_count", 64'(count), 64'd0);
        chk("wrp_rst_empty", 64'(empty), 64'd1);
        chk("wrp_rst_busy", 64'(cpu_busy), 64'd0);
        ins = 1'b0;
        #1 rstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("wrp_nores%0d", k), 64'(cpu_wr_result_valid), 64'd0);
        end
        for (int k = 0; k < 4; k++) begin
            cpu_rd_valid = 1'b1;
            cpu_rd_addr  = 4'(k);
            tick();
            cpu_rd_valid = 1'b0;
            chk($sformatf("wrp_entry%0d", k), 64'(cpu_rd_result), 64'd0);
            tick();
        end
`else
        // CPU channel compiled out: requests must have no visible effect.
        cpu_wr_valid = 1'b1;
        cpu_wr_addr  = 4'd0;
        cpu_wr_data  = 32'hDEAD_BEEF;
        cpu_rd_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("nocpu_busy%0d", k), 64'(cpu_busy), 64'd0);
            chk($sformatf("nocpu_rdv%0d", k), 64'(cpu_rd_result_valid), 64'd0);
            chk($sformatf("nocpu_wrv%0d", k), 64'(cpu_wr_result_valid), 64'd0);
            chk($sformatf("nocpu_rd%0d", k), 64'(cpu_rd_result), 64'd0);
            chk($sformatf("nocpu_head%0d", k), 64'(head_data), 64'd0);
        end
        cpu_wr_valid = 1'b0;
        cpu_rd_valid = 1'b0;
`endif

        // Randomized traffic against the queue model; small rank range forces ties.
        mq.delete();
        for (int c = 0; c < 800; c++) begin
            ins  = ($urandom_range(0, 99) < ((c % 200) < 100 ? 70 : 35));
            pop  = ($urandom_range(0, 99) < ((c % 200) < 100 ? 30 : 65));
            info = {1'($urandom_range(0, 1)), 19'($urandom_range(0, 15)),
                    12'($urandom_range(0, 4095))};
            model_step(ins, pop, info, exp_drop);
            tick();
            chk_status($sformatf("rnd%0d", c));
            chk($sformatf("rnd%0d_drop", c), 64'(drop), 64'(exp_drop));
        end
        ins = 1'b0;
        pop = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
